// File: rtl/sample_player.sv
// Streams samples from s_mem to the audio path with optional arithmetic-shift attenuation.
// Three cycles per sample (address, RAM read, capture) plus any stall on aud_ready.
module sample_player #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   num_samples,
  input  logic              loop_en,
  input  logic [1:0]        vol_shift,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] aud_data,
  output logic              aud_valid,
  input  logic              aud_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CAPT, S_SEND} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     r_num;
  logic [1:0]          r_shift;
  logic [DATA_W-1:0]   r_aud_data;
  logic                r_aud_valid;
  logic                r_done;
  logic                r_stop_pend;

  logic                w_start_go;
  logic                w_zero_done;
  logic                w_fin_done;
  logic                w_adv;
  logic                w_rewind;
  logic                w_capt;
  logic                w_xfer;
  logic                w_stop;
  logic                w_last;
  logic signed [DATA_W-1:0] w_shifted;

  // A stop raised in the very cycle of the handshake still counts as a stop.
  assign w_stop    = r_stop_pend | stop;
  assign w_last    = (r_cnt == r_num - 1'b1);
  assign w_shifted = $signed(mem_q) >>> r_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_go  = 1'b0;
    w_zero_done = 1'b0;
    w_fin_done  = 1'b0;
    w_adv       = 1'b0;
    w_rewind    = 1'b0;
    w_capt      = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_samples != '0) begin
            w_start_go  = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_zero_done = 1'b1;
          end
        end
      end
      S_FETCH: w_state_nxt = S_CAPT;
      S_CAPT: begin
        w_capt      = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (aud_ready) begin
          w_xfer = 1'b1;
          if (w_stop) begin
            w_state_nxt = S_IDLE;
          end else if (w_last) begin
            if (loop_en) begin
              w_rewind    = 1'b1;
              w_state_nxt = S_FETCH;
            end else begin
              w_fin_done  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_cnt       <= '0;
      r_num       <= '0;
      r_shift     <= '0;
      r_aud_data  <= '0;
      r_aud_valid <= 1'b0;
      r_done      <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_done <= w_zero_done | w_fin_done;
      if (w_start_go) begin
        r_num      <= num_samples;
        r_shift    <= vol_shift;
        r_mem_addr <= '0;
        r_cnt      <= '0;
      end
      if (w_rewind) begin
        r_mem_addr <= '0;
        r_cnt      <= '0;
      end
      if (w_adv) begin
        r_mem_addr <= r_mem_addr + 1'b1;
        r_cnt      <= r_cnt + 1'b1;
      end
      if (w_capt) begin
        r_aud_data  <= w_shifted;
        r_aud_valid <= 1'b1;
      end
      if (w_xfer) r_aud_valid <= 1'b0;
      // Cleared on every cycle that lands in IDLE, set by stop anywhere else.
      if (w_state_nxt == S_IDLE)              r_stop_pend <= 1'b0;
      else if (r_state != S_IDLE && stop)     r_stop_pend <= 1'b1;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign aud_data  = r_aud_data;
  assign aud_valid = r_aud_valid;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sample_player.sv
// Directed bench for sample_player with a behavioural one-cycle-latency s_mem model.
module tb_sample_player;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [8:0]  num_samples;
  logic        loop_en;
  logic [1:0]  vol_shift;
  logic [7:0]  mem_addr;
  logic [15:0] mem_q;
  logic [15:0] aud_data;
  logic        aud_valid;
  logic        aud_ready;
  logic        busy;
  logic        done;

  logic [15:0] mem [256];
  int n_assert = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;

  sample_player #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .num_samples(num_samples), .loop_en(loop_en), .vol_shift(vol_shift),
    .mem_addr(mem_addr), .mem_q(mem_q), .aud_data(aud_data),
    .aud_valid(aud_valid), .aud_ready(aud_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= mem[mem_addr];

  always @(posedge clk) begin
    if (rst_n && aud_valid && aud_ready) hs_cnt++;
    if (rst_n && done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (!aud_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic kick(input logic [8:0] num, input logic [1:0] sh);
    num_samples = num;
    vol_shift   = sh;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  initial begin
    int n;
    int errs;
    int hs0;
    int d0;
    int vseen;

    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; num_samples = '0;
    loop_en = 1'b0; vol_shift = '0; aud_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", aud_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", aud_data, 0);
    rst_n = 1'b1;
    tick();

    // Basic playback
    aud_ready = 1'b1;
    kick(9'd4, 2'd0);
    check("basic_busy_rise", busy, 1);
    check("basic_addr0", mem_addr, 0);
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) wait_valid(1, n);
      else begin tick(); wait_valid(1, n); end
      if (n != 3 || aud_data != 16'(k)) errs++;
    end
    check("basic_seq_errs", errs, 0);
    tick();
    check("basic_done", done, 1);
    check("basic_busy_fall", busy, 0);
    tick();
    check("basic_done_width", done, 0);

    // Back-pressure and attenuation
    mem[0] = 16'h8000;
    mem[1] = 16'h7FFF;
    aud_ready = 1'b0;
    kick(9'd2, 2'd2);
    wait_valid(1, n);
    check("bp_latency", n, 3);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (aud_valid !== 1'b1 || aud_data !== 16'hE000) errs++;
      tick();
    end
    check("bp_hold_errs", errs, 0);
    check("bp_data", aud_data, 32'hE000);
    hs0 = hs_cnt;
    aud_ready = 1'b1;
    tick();
    check("bp_one_xfer", hs_cnt - hs0, 1);
    check("bp_valid_drop", aud_valid, 0);
    wait_valid(1, n);
    check("bp_pos_shift", aud_data, 32'h1FFF);
    tick();
    check("bp_done", done, 1);
    mem[0] = 16'h0000;
    mem[1] = 16'h0001;

    // Full depth with loop
    loop_en = 1'b1;
    kick(9'd256, 2'd0);
    errs = 0;
    for (int k = 0; k < 256; k++) begin
      if (k == 0) wait_valid(1, n);
      else begin tick(); wait_valid(1, n); end
      if (n != 3 || aud_data != 16'(k)) errs++;
    end
    check("loop_pass1_errs", errs, 0);
    check("loop_addr_last", mem_addr, 255);
    tick();
    check("loop_addr_wrap", mem_addr, 0);
    check("loop_no_done", done, 0);
    loop_en = 1'b0;
    errs = 0;
    for (int k = 0; k < 256; k++) begin
      if (k == 0) wait_valid(1, n);
      else begin tick(); wait_valid(1, n); end
      if (n != 3 || aud_data != 16'(k)) errs++;
    end
    check("loop_pass2_errs", errs, 0);
    tick();
    check("loop_done", done, 1);
    check("loop_busy_fall", busy, 0);

    // Stop during a SEND stall, plus an ignored start
    aud_ready = 1'b0;
    kick(9'd4, 2'd0);
    wait_valid(1, n);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    num_samples = 9'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("stop_still_valid", aud_valid, 1);
    check("stop_addr_held", mem_addr, 0);
    hs0 = hs_cnt;
    d0 = done_cnt;
    aud_ready = 1'b1;
    tick();
    check("stop_xfer", hs_cnt - hs0, 1);
    check("stop_idle", busy, 0);
    for (int i = 0; i < 6; i++) tick();
    check("stop_no_done", done_cnt - d0, 0);
    check("stop_stay_idle", busy, 0);

    // Stop coinciding with the final handshake
    mem[0] = 16'h7FFF;
    d0 = done_cnt;
    kick(9'd1, 2'd3);
    wait_valid(1, n);
    check("fstop_shift3", aud_data, 32'h0FFF);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("fstop_busy", busy, 0);
    tick();
    check("fstop_no_done", done_cnt - d0, 0);
    mem[0] = 16'h0000;

    // Zero count
    kick(9'd0, 2'd0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    vseen = 0;
    for (int i = 0; i < 4; i++) begin
      if (aud_valid) vseen++;
      tick();
    end
    check("zero_done_width", done_cnt - d0, 1);
    check("zero_no_valid", vseen, 0);

    // Reset mid-play
    aud_ready = 1'b1;
    kick(9'd4, 2'd0);
    wait_valid(1, n);
    tick();
    aud_ready = 1'b0;
    wait_valid(1, n);
    check("mid_addr1", mem_addr, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", aud_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();
    aud_ready = 1'b1;
    kick(9'd4, 2'd0);
    check("mid_restart_addr", mem_addr, 0);
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) wait_valid(1, n);
      else begin tick(); wait_valid(1, n); end
      if (n != 3 || aud_data != 16'(k)) errs++;
    end
    check("mid_replay_errs", errs, 0);
    tick();
    check("mid_done", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_player.md
# sample_player

Streams 16-bit audio samples out of the 256×16 on-chip sample memory `s_mem` to the audio-output path through a valid/ready handshake. The flash reader loads `s_mem` with 256 samples; this block runs after it, reading those samples back in address order. It applies an optional arithmetic-right-shift attenuation and plays once or loops. It is the owner of `s_mem`'s read port while busy.

## Interface

**Parameters**
- `ADDR_W`, default 8: sample memory address width (depth 2^ADDR_W).
- `DATA_W`, default 16: sample width; samples are two's-complement.

**Ports**
- `clk`, in, 1: single clock, the 50 MHz system clock.
- `rst_n`, in, 1: reset. **Synchronous and active-low.**
- `start`, in, 1: begin playback. Sampled only in IDLE; ignored while busy.
- `stop`, in, 1: request abort at the next sample boundary.
- `num_samples`, in, ADDR_W+1: samples per pass, range 0..256. Latched at start.
- `loop_en`, in, 1: restart at address 0 after the last sample. Evaluated live at each final handshake.
- `vol_shift`, in, 2: attenuation as an arithmetic right shift of 0..3. Latched at start.
- `mem_addr`, out, ADDR_W: read address to `s_mem`. Registered.
- `mem_q`, in, DATA_W: `s_mem` read data. Valid one cycle after `mem_addr` is presented.
- `aud_data`, out, DATA_W: attenuated sample.
- `aud_valid`, out, 1: `aud_data` is valid.
- `aud_ready`, in, 1: consumer accepts the sample when `aud_valid` and `aud_ready` are both high.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a non-looping pass completes.

## Operation

**States:** IDLE, FETCH, CAPT, SEND.

- **IDLE**
  - On `start` with `num_samples`≠0: latch `num_samples` and `vol_shift`; set `mem_addr`←0 and `cnt`←0; go to FETCH.
  - On `start` with `num_samples`=0: pulse `done` on the next cycle and stay in IDLE.
- **FETCH:** `mem_addr` is held stable for the RAM's address register. Go to CAPT.
- **CAPT:**
  - `aud_data` ← `mem_q >>> vol_shift`, sign-extended.
  - `aud_valid` ← 1.
  - Go to SEND.
- **SEND:** hold `aud_data` and `aud_valid` until the handshake. On handshake:
  - `aud_valid` ← 0.
  - If `stop` is pending, go to IDLE. `done` is not pulsed.
  - Else if `cnt` = latched count − 1:
    - with `loop_en`=1: `mem_addr`←0, `cnt`←0, go to FETCH;
    - with `loop_en`=0: go to IDLE and pulse `done`.
  - Otherwise `mem_addr`+1, `cnt`+1, go to FETCH.
- **stop:** a `stop` asserted in any non-IDLE state sets a sticky `stop_pend` flag. The flag is cleared on entry to IDLE. A sample that is already valid is always delivered; `aud_valid` never drops without a handshake, except on reset.
- **Widths:**
  - `cnt` is ADDR_W+1 bits wide, so a count of 256 is representable.
  - `mem_addr` wraps from 255 to 0 only through the loop path.
- **Sign:** the shift is sign-preserving, e.g. 0x8000 >>> 2 = 0xE000 and 0x7FFF >>> 3 = 0x0FFF.

## Timing

- **Reset values** (at the first clock edge with `rst_n`=0): state IDLE; `mem_addr`=0; `aud_data`=0; `aud_valid`=0; `busy`=0; `done`=0; `stop_pend`=0.
- **Reset mid-operation:** all outputs take their reset values at that same edge, and `aud_valid` drops immediately.
- **Start latency:** `start` is sampled at edge 0.
  - Cycle 1 (FETCH): `mem_addr` = 0.
  - Cycle 2 (CAPT): `mem_q` is valid.
  - Cycle 3: `aud_valid` = 1.
- **Throughput:** one sample per 3 cycles plus any stall on `aud_ready`. A handshake at cycle n puts the next `aud_valid` high at cycle n+3.
- **`busy`:** rises the cycle after `start` is accepted. Falls in the same cycle that `done` pulses, one cycle after the final handshake.
- **`done`:** exactly one cycle wide.
- **Simultaneous events:**
  - `start` together with `stop` in IDLE: `start` wins; `stop` is ignored.
  - `stop` during the final handshake cycle: treated as a stop, so no `done` pulse.

## Test plan

- **Basic playback:** preload `s_mem[i]`=i, `num_samples`=4, `vol_shift`=0, `aud_ready` held at 1.
  - Expect `aud_data` 0,1,2,3, with valid first high 3 cycles after `start` and at a 3-cycle spacing.
  - Expect `done` one cycle after the 4th handshake, then `busy`=0.
- **Back-pressure and attenuation:** `aud_ready`=0 for 10 cycles while valid; `s_mem[0]`=0x8000, `vol_shift`=2.
  - `aud_data` holds 0xE000 and `aud_valid` stays high for all 10 cycles.
  - Exactly one transfer occurs once `aud_ready` rises.
- **Full depth with loop:** `num_samples`=256, `loop_en`=1.
  - After sample 255, `mem_addr` returns to 0 and the next sample is `s_mem[0]`.
  - Clear `loop_en`; the second pass ends with `done`.
- **Stop:** assert `stop` for one cycle during a SEND stall, then raise `aud_ready`.
  - The current sample transfers, the block goes to IDLE, and there is no `done` pulse.
  - A `start` pulse while busy is ignored.
- **Zero count:** `num_samples`=0 with `start`.
  - `done` pulses the next cycle, `busy` stays 0, and `aud_valid` never rises.
- **Reset mid-play:** hold `rst_n`=0 for one edge while in SEND.
  - `aud_valid`, `busy`, and `mem_addr` read 0 after that edge.
  - A fresh `start` replays from address 0.
